// File: rtl/uart_tx_full.sv
// UART transmitter: 6/7/8 data bits, none/even/odd parity, 1/1.5/2 stop bits, 16x oversampled.
// Latency: start accepted on the next edge without waiting for a baud tick; line changes on the edge that selects each bit.
// Backpressure: i_tx_start is only sampled in IDLE; o_busy is high otherwise and requests arriving then are dropped.
module uart_tx_full (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_baud_tick,
  input  logic       i_tx_start,
  input  logic [7:0] i_data,
  input  logic [1:0] i_data_num,
  input  logic [1:0] i_stop_num,
  input  logic [1:0] i_par,
  output logic       o_tx,
  output logic       o_tx_done_tick,
  output logic       o_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic [1:0] dnum_q, dnum_d;
  logic [1:0] snum_q, snum_d;
  logic [1:0] par_q, par_d;
  logic       tx_q, tx_d;
  logic       done_c;

  logic [2:0] last_bit;
  logic [4:0] stop_last;
  logic [7:0] data_mask;
  logic       par_en;
  logic       par_bit;
  logic [2:0] bit_nxt;

  // Frame shape comes only from the copies taken when the frame was accepted.
  always_comb begin
    case (dnum_q)
      2'b00:   begin last_bit = 3'd5; data_mask = 8'h3F; end
      2'b01:   begin last_bit = 3'd6; data_mask = 8'h7F; end
      default: begin last_bit = 3'd7; data_mask = 8'hFF; end
    endcase
    case (snum_q)
      2'b00:   stop_last = 5'd15;
      2'b01:   stop_last = 5'd23;
      default: stop_last = 5'd31;
    endcase
    par_en  = (par_q == 2'b01) || (par_q == 2'b10);
    par_bit = (^(data_q & data_mask)) ^ (par_q == 2'b10);
    bit_nxt = bit_q + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    dnum_d  = dnum_q;
    snum_d  = snum_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (i_tx_start) begin
          state_d = START;
          tick_d  = 5'd0;
          bit_d   = 3'd0;
          data_d  = i_data;
          dnum_d  = i_data_num;
          snum_d  = i_stop_num;
          par_d   = i_par;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (i_baud_tick) begin
          if (tick_q == 5'd15) begin
            tick_d  = 5'd0;
            state_d = DATA;
            tx_d    = data_q[0];
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_baud_tick) begin
          if (tick_q == 5'd15) begin
            tick_d = 5'd0;
            if (bit_q == last_bit) begin
              state_d = par_en ? PARITY : STOP;
              tx_d    = par_en ? par_bit : 1'b1;
            end else begin
              bit_d = bit_nxt;
              tx_d  = data_q[bit_nxt];
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (i_baud_tick) begin
          if (tick_q == 5'd15) begin
            tick_d  = 5'd0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (i_baud_tick) begin
          if (tick_q == stop_last) begin
            tick_d  = 5'd0;
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      tick_q  <= 5'd0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      dnum_q  <= 2'd0;
      snum_q  <= 2'd0;
      par_q   <= 2'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      dnum_q  <= dnum_d;
      snum_q  <= snum_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // A frame cut short by reset must never report completion.
  assign o_tx_done_tick = done_c & ~i_reset;
  assign o_tx           = tx_q;
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_full.sv
// Directed bench for uart_tx_full: fixed frames, mid-frame disturbance, reset abort, FIFO-fed streaming.
module tb_uart_tx_full;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       baud_tick = 1'b0;
  logic       tx_start;
  logic [7:0] data;
  logic [1:0] data_num, stop_num, par;
  logic       tx, done, busy;

  logic       man_start;
  logic [7:0] man_data;
  logic       fifo_mode = 1'b0;
  logic [7:0] fifo_mem [4];
  logic [2:0] fifo_wr = 3'd0;
  logic [2:0] fifo_rd = 3'd0;
  logic [1:0] bdiv = 2'd0;

  assign tx_start = fifo_mode ? (fifo_wr != fifo_rd) : man_start;
  assign data     = fifo_mode ? fifo_mem[fifo_rd[1:0]] : man_data;

  uart_tx_full dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_baud_tick    (baud_tick),
    .i_tx_start     (tx_start),
    .i_data         (data),
    .i_data_num     (data_num),
    .i_stop_num     (stop_num),
    .i_par          (par),
    .o_tx           (tx),
    .o_tx_done_tick (done),
    .o_busy         (busy)
  );

  // Baud tick every fourth clock, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (bdiv == 2'd3);
      bdiv = bdiv + 2'd1;
    end
  end

  logic line_mem [0:4095];
  int   tot_ticks = 0;
  int   fstart = 0;
  int   done_cnt = 0;
  int   idle_run = 0;
  int   last_gap = 0;
  int   gap_low = 0;
  logic prev_busy = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) fstart = tot_ticks;
    prev_busy = busy;
    if (busy === 1'b1 && baud_tick) begin
      if (tot_ticks < 4096) line_mem[tot_ticks] = tx;
      tot_ticks++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (fifo_mode) fifo_rd = fifo_rd + 3'd1;
    end
    if (busy === 1'b0) begin
      idle_run++;
      if (tx !== 1'b1) gap_low++;
    end else if (busy === 1'b1) begin
      if (idle_run != 0) last_gap = idle_run;
      idle_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 4000) begin
      step();
      n++;
    end
    check({tag, "_done"}, done_cnt, target);
  endtask

  // exp_bits[0] is the start bit, then data LSB first, then parity if any.
  task automatic check_frame(input string tag, input logic [15:0] exp_bits, input int nb, input int stop_t);
    int s = fstart;
    int ones = 0;
    logic [15:0] v;
    check({tag, "_ticks"}, tot_ticks - s, 16 * nb + stop_t);
    for (int k = 0; k < nb; k++) begin
      for (int t = 0; t < 16; t++) v[t] = line_mem[(s + 16 * k + t) % 4096];
      check($sformatf("%s_bit%0d", tag, k), v, exp_bits[k] ? 16'hFFFF : 16'h0000);
    end
    for (int t = 0; t < stop_t; t++) if (line_mem[(s + 16 * nb + t) % 4096] === 1'b1) ones++;
    check({tag, "_stop"}, ones, stop_t);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [1:0] dn, input logic [1:0] sn, input logic [1:0] p);
    step();
    man_data = d; data_num = dn; stop_num = sn; par = p; man_start = 1'b1;
    step();
    man_start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] dn, input logic [1:0] sn,
                           input logic [1:0] p, input logic perturb, input logic [15:0] exp_bits,
                           input int nb, input int stop_t);
    int d0 = done_cnt;
    start_frame(d, dn, sn, p);
    if (perturb) begin
      for (int i = 0; i < 300; i++) begin
        step();
        man_data  = 8'($urandom_range(0, 255));
        data_num  = 2'($urandom_range(0, 3));
        stop_num  = 2'($urandom_range(0, 3));
        par       = 2'($urandom_range(0, 3));
        man_start = ($urandom_range(0, 3) == 0);
      end
      step();
      man_start = 1'b0;
    end
    wait_done(d0 + 1, tag);
    check_frame(tag, exp_bits, nb, stop_t);
    repeat (8) step();
    check({tag, "_one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int n;
    rst = 1'b1; man_start = 1'b1; man_data = 8'hFF;
    data_num = 2'b10; stop_num = 2'b00; par = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();
    rst = 1'b0; man_start = 1'b0;
    repeat (3) step();

    run_frame("f8n1_7c", 8'h7C, 2'b10, 2'b00, 2'b00, 1'b0, 16'b0_0111_1100_0, 9, 16);
    run_frame("f7e15_3d", 8'h3D, 2'b01, 2'b01, 2'b01, 1'b0, 16'b1_0111_1010, 9, 24);
    run_frame("f6o2_de", 8'hDE, 2'b00, 2'b10, 2'b10, 1'b0, 16'b1011_1100, 8, 32);
    run_frame("perturb", 8'h7C, 2'b10, 2'b00, 2'b00, 1'b1, 16'b0_0111_1100_0, 9, 16);

    // Abort in data bit 3 (frame ticks 64..79).
    d0 = done_cnt;
    start_frame(8'h7C, 2'b10, 2'b00, 2'b00);
    n = 0;
    while (tot_ticks - fstart < 70 && n < 2000) begin
      step();
      n++;
    end
    check("abort_reach", (tot_ticks - fstart) >= 70, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    step();
    rst = 1'b0;
    repeat (40) step();
    check("abort_no_done", done_cnt, d0);
    run_frame("after_rst_a5", 8'hA5, 2'b11, 2'b00, 2'b11, 1'b0, 16'b1_0100_1010, 9, 16);

    // FIFO-fed stream: start = ~empty, pop on done.
    d0 = done_cnt;
    data_num = 2'b10; stop_num = 2'b00; par = 2'b00;
    fifo_mem[0] = 8'h01; fifo_mem[1] = 8'h02; fifo_mem[2] = 8'h03; fifo_mem[3] = 8'h04;
    step();
    fifo_rd = 3'd0;
    fifo_wr = 3'd4;
    fifo_mode = 1'b1;
    wait_done(d0 + 1, "fifo1");
    check_frame("fifo1", 16'b0_0000_0010, 9, 16);
    wait_done(d0 + 2, "fifo2");
    check_frame("fifo2", 16'b0_0000_0100, 9, 16);
    check("fifo2_gap", last_gap, 1);
    wait_done(d0 + 3, "fifo3");
    check_frame("fifo3", 16'b0_0000_0110, 9, 16);
    check("fifo3_gap", last_gap, 1);
    wait_done(d0 + 4, "fifo4");
    check_frame("fifo4", 16'b0_0000_1000, 9, 16);
    check("fifo4_gap", last_gap, 1);
    check("fifo_empty", fifo_wr - fifo_rd, 0);
    repeat (40) step();
    check("fifo_idle_busy", busy, 0);
    check("fifo_no_extra", done_cnt, d0 + 4);
    check("idle_high", gap_low, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_full.md
UART_TX_FULL -- requirements
Module: uart_tx_full

Interface
REQ-001 SHALL have no parameters; data width is fixed at 8 and oversampling is fixed at 16 ticks per bit.
REQ-002 SHALL have port i_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_baud_tick, input, 1: one-clock pulse at 16x the baud rate, from baud_rate_generator.
REQ-005 SHALL have port i_tx_start, input, 1: request to send i_data; sampled only in IDLE.
REQ-006 SHALL have port i_data, input, 8: frame payload, LSB first.
REQ-007 SHALL have port i_data_num, input, 2: 00 = 6 bits, 01 = 7 bits, 10 or 11 = 8 bits.
REQ-008 SHALL have port i_stop_num, input, 2: 00 = 16 ticks, 01 = 24 ticks, 10 or 11 = 32 ticks.
REQ-009 SHALL have port i_par, input, 2: 00 or 11 = no parity, 01 = even, 10 = odd.
REQ-010 SHALL have port o_tx, output, 1: serial line, registered, idle high.
REQ-011 SHALL have port o_tx_done_tick, output, 1: one-clock pulse at the end of the stop period.
REQ-012 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-014 IDLE with i_tx_start=1 SHALL, on the next edge, enter START, clear the tick counter and data-bit counter, and latch i_data, i_data_num, i_stop_num and i_par.
REQ-015 This IDLE-to-START transition SHALL NOT wait for i_baud_tick.
REQ-016 After leaving IDLE, the FSM SHALL use only the latched values; input changes mid-frame SHALL have no effect.
REQ-017 i_tx_start outside IDLE SHALL be ignored, with no queuing.
REQ-018 In START, DATA and PARITY, the tick counter (5 bits) SHALL advance only on i_baud_tick, and the bit SHALL end on the tick where the counter equals 15.
REQ-019 On that ending tick the counter SHALL wrap to 0.
REQ-020 START SHALL drive o_tx=0 and then go to DATA.
REQ-021 DATA SHALL drive o_tx=data[n], where n is the bit counter starting at 0.
REQ-022 After bit n = N-1 (N = 6/7/8), DATA SHALL go to PARITY if parity is enabled, else to STOP.
REQ-023 PARITY SHALL drive o_tx equal to the XOR of the N data bits for even parity, or its inverse for odd parity; unsent MSBs SHALL be excluded.
REQ-024 PARITY SHALL then go to STOP.
REQ-025 STOP SHALL drive o_tx=1 and end on the i_baud_tick where the counter equals stop_ticks-1 (15/23/31).
REQ-026 On that tick, o_tx_done_tick SHALL be 1 for that single clock, and the FSM SHALL go to IDLE on the next edge.
REQ-027 The done tick and IDLE SHALL NOT overlap, so i_tx_start held high during the done cycle is not accepted until the following IDLE cycle.
REQ-028 Back-to-back frames SHALL have a gap of at least one clock of line high after the stop period.
REQ-029 The total frame length in ticks SHALL be 16*(1+N+P) + stop_ticks, where P = 1 if parity is enabled.
REQ-030 o_tx SHALL be registered and glitch-free; it SHALL change on the same edge as the state or counter update that selects the new bit.
REQ-031 The intended connection SHALL be i_tx_start = ~fifo_empty, with the FIFO read strobe driven by o_tx_done_tick.

Reset
REQ-032 i_reset=1 at an edge SHALL force IDLE, both counters = 0, o_tx=1, o_tx_done_tick=0 and o_busy=0, from any state.
REQ-033 A frame aborted by reset SHALL produce no done tick.
REQ-034 i_tx_start sampled in the same cycle as i_reset SHALL be ignored, since reset wins.

Verification
REQ-035 Bench SHALL cover 8N1, data 0x7C, stop 00 -> line 0 | 0,0,1,1,1,1,1,0 | 1, with each bit lasting 16 ticks, stop lasting 16 ticks, 160 ticks total and exactly one done pulse.
REQ-036 Bench SHALL cover 7 bits, even parity, 1.5 stop, data 0x3D -> data 1,0,1,1,1,1,0 followed by parity 1, stop high for 24 ticks and 168 ticks total.
REQ-037 Bench SHALL cover 6 bits, odd parity, 2 stop, data 0xDE -> data 0,1,1,1,1,0 (bits 7:6 ignored) followed by parity 1, stop high for 32 ticks and 160 ticks total.
REQ-038 Bench SHALL cover i_tx_start pulses and i_data/i_par/i_data_num changes mid-frame -> the line is identical to the unperturbed frame, with one done pulse.
REQ-039 Bench SHALL cover i_reset=1 during DATA bit 3 -> on the next edge o_tx=1, o_busy=0 and no done pulse; a new frame started afterwards is correct.
REQ-040 Bench SHALL cover a 4-deep FIFO loaded with 0x01..0x04, start tied to ~empty and read tied to done -> four back-to-back frames in order, one idle-high clock between frames, and empty asserted after the fourth done pulse.
